div_seq: RTL and testbench

//  Multi-cycle divide sequencer for the EX stage. It owns a single iterative

---
 rtl/div_seq_pkg.sv | 23 ++
 rtl/div_step.sv | 34 +++
 rtl/div_seq.sv | 161 ++++++++++++++++
 tb/tb_div_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
//==============================================================================
// Module      : div_seq_pkg
// Description : Shared types and constants for the divide sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_seq_pkg;

    localparam int unsigned c_DIV_DATA_W = 32;
    localparam int unsigned c_DIV_CNT_W  = 6;

    // DivFree / DivByZero / DivOn / DivEnd
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DZERO = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//==============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration (shift, compare,
//               conditional subtract) on a {remainder, quotient} pair.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_diff;
    logic              w_ge;

    // The remainder stays below the divisor, so the difference always fits in
    // DATA_W bits even though the shifted value needs one more.
    assign w_shift = {rem_i, quo_i[DATA_W-1]};
    assign w_ge    = (w_shift >= {1'b0, divisor_i});
    assign w_diff  = w_shift[DATA_W-1:0] - divisor_i;

    assign rem_o = w_ge ? w_diff : w_shift[DATA_W-1:0];
    assign quo_o = {quo_i[DATA_W-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
//==============================================================================
// Module      : div_seq
// Description : Multi-cycle radix-2 restoring divide sequencer for div/divu,
//               returning {remainder, quotient} and stalling EX while busy.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = c_DIV_DATA_W,
    parameter int CNT_W  = c_DIV_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o,
    output logic                div_zero_o
);

    div_state_t          r_state;
    div_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*DATA_W-1:0] r_result;
    logic                r_div_zero;

    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W-1:0]   w_op1_abs;
    logic [DATA_W-1:0]   w_op2_abs;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic                w_accept;
    logic                w_zero_div;
    logic                w_last;

    assign w_accept   = start_i & ~annul_i;
    assign w_zero_div = (opdata2_i == '0);
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

    // Magnitude of 0x80000000 is itself when read as unsigned, so no special case.
    assign w_op1_abs = (signed_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_op2_abs = (signed_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    div_step #(
        .DATA_W    (DATA_W)
    ) u_div_step (
        .rem_i     (r_rem),
        .quo_i     (r_quo),
        .divisor_i (r_divisor),
        .rem_o     (w_rem_nxt),
        .quo_o     (w_quo_nxt)
    );

    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stallreq_o  = 1'b0;
        ready_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stallreq_o  = 1'b1;
                    w_state_nxt = w_zero_div ? S_DZERO : S_BUSY;
                end
            end
            S_DZERO: begin
                stallreq_o  = 1'b1;
                w_state_nxt = annul_i ? S_IDLE : S_DONE;
            end
            S_BUSY: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ready_o = 1'b1;
                // Holding start_i keeps the result presented; no restart until it drops.
                if (annul_i || !start_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_zero_div) begin
                        r_divisor <= w_op2_abs;
                        r_quo     <= w_op1_abs;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_neg_q   <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        r_neg_r   <= signed_i & opdata1_i[DATA_W-1];
                    end
                end
                S_BUSY: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result   <= {w_rem_fix, w_quo_fix};
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                S_DZERO: begin
                    if (!annul_i) begin
                        r_result   <= '0;
                        r_div_zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = r_result;
    assign div_zero_o = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
//==============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
    logic        div_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_last;
    logic        exp_dz;

    div_seq #(
        .DATA_W     (32),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o),
        .div_zero_o (div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {div_zero, remainder, quotient} from 64-bit integer arithmetic.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y, q, r;
        if (b == 32'd0) return {1'b1, 64'd0};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Issue one divide, hold start until ready (+hold extra cycles), check it.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        logic [64:0] m;
        int          lat;
        int          cyc;
        int          bad;
        m   = model(a, b, s);
        lat = m[64] ? 2 : 33;
        bad = 0;
        @(negedge clk);
        start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
        #1;
        if (stallreq_o !== 1'b1) bad++;
        cyc = 0;
        while (ready_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            opdata1_i = $urandom; opdata2_i = $urandom; signed_i = 1'($urandom);
            #1;
            if (stallreq_o !== ((cyc < lat) ? 1'b1 : 1'b0)) bad++;
        end
        check({tag, ":latency"}, 64'(cyc), 64'(lat));
        check({tag, ":result"}, result_o, m[63:0]);
        check({tag, ":div_zero"}, 64'(div_zero_o), 64'(m[64]));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            if (ready_o !== 1'b1 || stallreq_o !== 1'b0 || result_o !== m[63:0]) bad++;
        end
        check({tag, ":stall_pattern"}, 64'(bad), 64'd0);
        start_i  = 1'b0;
        exp_last = m[63:0];
        exp_dz   = m[64];
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset:result", result_o, 64'd0);
        check("reset:ready", 64'(ready_o), 64'd0);
        check("reset:stall", 64'(stallreq_o), 64'd0);
        check("reset:div_zero", 64'(div_zero_o), 64'd0);
        rst = 1'b0;

        check("model:100/7", {32'd2, 32'd14}, model(32'd100, 32'd7, 1'b0));
        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 0);
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        check("const:m7_2", exp_last, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        check("const:7_m2", exp_last, {32'h0000_0001, 32'hFFFF_FFFD});
        do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 0);
        do_div("divu_after_zero", 32'd9, 32'd3, 1'b0, 0);
        do_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        check("const:min_m1", exp_last, {32'd0, 32'h8000_0000});
        do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_div("divu_small", 32'd3, 32'd1000, 1'b0, 0);

        // Annul at cycle 10: idle at 11, no ready, result retained.
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        #1;
        check("annul:stall", 64'(stallreq_o), 64'd0);
        check("annul:ready", 64'(ready_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen++;
        end
        check("annul:never_ready", 64'(seen), 64'd0);
        check("annul:result_kept", result_o, exp_last);
        check("annul:div_zero_kept", 64'(div_zero_o), 64'(exp_dz));

        // Start and annul together in IDLE: no stall, no activity.
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd0;
        seen = 0;
        repeat (6) begin
            #1;
            if (stallreq_o !== 1'b0 || ready_o !== 1'b0) seen++;
            @(negedge clk);
        end
        check("start_annul:idle", 64'(seen), 64'd0);
        check("start_annul:div_zero", 64'(div_zero_o), 64'(exp_dz));
        start_i = 1'b0; annul_i = 1'b0;

        // Hold start after ready, then back-to-back divide.
        do_div("hold3", 32'd1000, 32'd33, 1'b0, 3);
        do_div("back2back", 32'hFFFF_FC18, 32'd33, 1'b1, 0);

        // Reset in the middle of a divide.
        do_div("div_zero_pre_rst", 32'd77, 32'd0, 1'b1, 0);
        do_div("pre_rst", 32'd999, 32'd10, 1'b0, 0);
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd4000; opdata2_i = 32'd3;
        repeat (20) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid:result", result_o, 64'd0);
        check("rst_mid:ready", 64'(ready_o), 64'd0);
        check("rst_mid:stall", 64'(stallreq_o), 64'd0);
        check("rst_mid:div_zero", 64'(div_zero_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
            do_div("random", ra, rb, 1'($urandom), 32'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
